// File: rtl/writeback_unit_pkg.sv
// Shared write-back types: per-pipe result records, register-file write port
// and the winning-pipe encoding used by the result selector.
package defines;

   localparam int unsigned REG_WIDTH  = 32;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  register_write;
      logic [REG_WIDTH-1:0]  result;
      logic                  redirect;
      logic [31:0]           target;
   } alu_wb_inf_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  register_write;
      logic [REG_WIDTH-1:0]  result;
      logic                  replay;
      logic [31:0]           pc;
   } lst_wb_inf_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_WIDTH-1:0]  result;
   } mul_wb_inf_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_WIDTH-1:0]  result;
   } div_wb_inf_t;

   typedef struct packed {
      logic                  wr_en;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_WIDTH-1:0]  wr_data;
   } wb_ix_inf_t;

   typedef enum logic [2:0] {
      SEL_NONE = 3'd0,
      SEL_ALU  = 3'd1,
      SEL_LST  = 3'd2,
      SEL_MUL  = 3'd3,
      SEL_DIV  = 3'd4
   } wb_pipe_e;

endpackage

// File: rtl/writeback_unit_result_select.sv
// Combinational fixed-priority (DIV > MUL > LST > ALU) result selector with
// same-cycle collision detection; squash masking is applied by the caller.
module wb_result_select
   import defines::*;
(
   input  logic                  i_alu_valid,
   input  alu_wb_inf_t           i_alu,
   input  logic                  i_lst_valid,
   input  lst_wb_inf_t           i_lst,
   input  logic                  i_mul_valid,
   input  mul_wb_inf_t           i_mul,
   input  logic                  i_div_valid,
   input  div_wb_inf_t           i_div,
   output wb_pipe_e              o_sel,
   output logic                  o_wr_en,
   output logic [REG_ADDR_W-1:0] o_rd,
   output logic [REG_WIDTH-1:0]  o_wr_data,
   output logic                  o_branch,
   output logic [31:0]           o_target,
   output logic                  o_collision
);

   logic [3:0] w_valid_vec;

   assign w_valid_vec = {i_div_valid, i_mul_valid, i_lst_valid, i_alu_valid};
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign o_collision = (w_valid_vec & (w_valid_vec - 4'd1)) != 4'd0;

   always_comb begin
      o_sel     = SEL_NONE;
      o_wr_en   = 1'b0;
      o_rd      = '0;
      o_wr_data = '0;
      o_branch  = 1'b0;
      o_target  = '0;
      if (i_div_valid) begin
         o_sel     = SEL_DIV;
         o_wr_en   = 1'b1;
         o_rd      = i_div.rd;
         o_wr_data = i_div.result;
      end else if (i_mul_valid) begin
         o_sel     = SEL_MUL;
         o_wr_en   = 1'b1;
         o_rd      = i_mul.rd;
         o_wr_data = i_mul.result;
      end else if (i_lst_valid) begin
         o_sel     = SEL_LST;
         o_rd      = i_lst.rd;
         o_wr_data = i_lst.result;
         if (i_lst.replay) begin
            o_branch = 1'b1;
            o_target = i_lst.pc;
         end else begin
            o_wr_en  = i_lst.register_write;
         end
      end else if (i_alu_valid) begin
         o_sel     = SEL_ALU;
         o_wr_en   = i_alu.register_write;
         o_rd      = i_alu.rd;
         o_wr_data = i_alu.result;
         o_branch  = i_alu.redirect;
         o_target  = i_alu.redirect ? i_alu.target : 32'd0;
      end
   end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: selects one execution-pipe result per cycle, writes the
// register file, issues redirects, squashes wrong-path ALU/LST results and retires.
module writeback_unit
   import defines::*;
#(
   parameter int unsigned SQUASH_CYCLES = 2,
   parameter int unsigned INSTRET_WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_wb_valid,
   input  alu_wb_inf_t              alu_wb_inf,
   input  logic                     lst_wb_valid,
   input  lst_wb_inf_t              lst_wb_inf,
   input  logic                     mul_wb_valid,
   input  mul_wb_inf_t              mul_wb_inf,
   input  logic                     div_wb_valid,
   input  div_wb_inf_t              div_wb_inf,
   output wb_ix_inf_t               wb_ix_inf,
   output logic                     wb_do_branch,
   output logic [31:0]              wb_branch_target,
   output logic [INSTRET_WIDTH-1:0] wb_instret,
   output logic                     wb_collision_err
);

   localparam int unsigned SQW = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

   logic [SQW-1:0]           r_squash;
   wb_ix_inf_t               r_wb_ix_inf;
   logic                     r_do_branch;
   logic [31:0]              r_branch_target;
   logic [INSTRET_WIDTH-1:0] r_instret;
   logic                     r_collision_err;

   logic                     w_squashing;
   logic                     w_alu_valid;
   logic                     w_lst_valid;
   wb_pipe_e                 w_sel;
   logic                     w_wr_en;
   logic [REG_ADDR_W-1:0]    w_rd;
   logic [REG_WIDTH-1:0]     w_wr_data;
   logic                     w_branch;
   logic [31:0]              w_target;
   logic                     w_collision;
   logic                     w_retire;

   assign w_squashing = (r_squash != '0);
   assign w_alu_valid = alu_wb_valid && !w_squashing;
   assign w_lst_valid = lst_wb_valid && !w_squashing;

   wb_result_select u_select (
      .i_alu_valid (w_alu_valid),
      .i_alu       (alu_wb_inf),
      .i_lst_valid (w_lst_valid),
      .i_lst       (lst_wb_inf),
      .i_mul_valid (mul_wb_valid),
      .i_mul       (mul_wb_inf),
      .i_div_valid (div_wb_valid),
      .i_div       (div_wb_inf),
      .o_sel       (w_sel),
      .o_wr_en     (w_wr_en),
      .o_rd        (w_rd),
      .o_wr_data   (w_wr_data),
      .o_branch    (w_branch),
      .o_target    (w_target),
      .o_collision (w_collision)
   );

   // An LST winner that branches is a replay: it re-executes, so it does not retire.
   assign w_retire = (w_sel != SEL_NONE) && !((w_sel == SEL_LST) && w_branch);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_squash        <= '0;
         r_wb_ix_inf     <= '0;
         r_do_branch     <= 1'b0;
         r_branch_target <= '0;
         r_instret       <= '0;
         r_collision_err <= 1'b0;
      end else begin
         r_wb_ix_inf.wr_en   <= w_wr_en && (w_rd != '0);
         r_wb_ix_inf.rd      <= w_rd;
         r_wb_ix_inf.wr_data <= w_wr_data;
         r_do_branch         <= w_branch;
         r_branch_target     <= w_target;
         if (w_retire)
            r_instret <= r_instret + INSTRET_WIDTH'(1);
         if (w_collision)
            r_collision_err <= 1'b1;
         if (w_branch)
            r_squash <= SQW'(SQUASH_CYCLES);
         else if (w_squashing)
            r_squash <= r_squash - SQW'(1);
      end
   end

   assign wb_ix_inf        = r_wb_ix_inf;
   assign wb_do_branch     = r_do_branch;
   assign wb_branch_target = r_branch_target;
   assign wb_instret       = r_instret;
   assign wb_collision_err = r_collision_err;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_writeback_unit;
   import defines::*;

   localparam int unsigned SQ = 2;
   localparam int unsigned IW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          alu_wb_valid = 1'b0;
   alu_wb_inf_t   alu_wb_inf = '0;
   logic          lst_wb_valid = 1'b0;
   lst_wb_inf_t   lst_wb_inf = '0;
   logic          mul_wb_valid = 1'b0;
   mul_wb_inf_t   mul_wb_inf = '0;
   logic          div_wb_valid = 1'b0;
   div_wb_inf_t   div_wb_inf = '0;
   wb_ix_inf_t    wb_ix_inf;
   logic          wb_do_branch;
   logic [31:0]   wb_branch_target;
   logic [IW-1:0] wb_instret;
   logic          wb_collision_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   int unsigned m_squash = 0;
   int unsigned m_instret = 0;
   bit          m_coll = 0;

   writeback_unit #(.SQUASH_CYCLES(SQ), .INSTRET_WIDTH(IW)) dut (
      .clk              (clk),
      .rst              (rst),
      .alu_wb_valid     (alu_wb_valid),
      .alu_wb_inf       (alu_wb_inf),
      .lst_wb_valid     (lst_wb_valid),
      .lst_wb_inf       (lst_wb_inf),
      .mul_wb_valid     (mul_wb_valid),
      .mul_wb_inf       (mul_wb_inf),
      .div_wb_valid     (div_wb_valid),
      .div_wb_inf       (div_wb_inf),
      .wb_ix_inf        (wb_ix_inf),
      .wb_do_branch     (wb_do_branch),
      .wb_branch_target (wb_branch_target),
      .wb_instret       (wb_instret),
      .wb_collision_err (wb_collision_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      alu_wb_valid = 1'b0;
      lst_wb_valid = 1'b0;
      mul_wb_valid = 1'b0;
      div_wb_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".wr_en"},  64'(wb_ix_inf.wr_en), 64'd0);
      check({tag, ".rd"},     64'(wb_ix_inf.rd), 64'd0);
      check({tag, ".data"},   64'(wb_ix_inf.wr_data), 64'd0);
      check({tag, ".branch"}, 64'(wb_do_branch), 64'd0);
      check({tag, ".target"}, 64'(wb_branch_target), 64'd0);
      check({tag, ".instret"},64'(wb_instret), 64'd0);
      check({tag, ".coll"},   64'(wb_collision_err), 64'd0);
   endtask

   task automatic model_reset();
      m_squash  = 0;
      m_instret = 0;
      m_coll    = 0;
   endtask

   // Inputs are already driven; predict the post-edge outputs, clock, then compare.
   task automatic step(input string tag);
      bit a_ok, l_ok, e_we, e_br, ret;
      int unsigned e_rd, e_data, e_tgt, n_valid;
      a_ok = alu_wb_valid && (m_squash == 0);
      l_ok = lst_wb_valid && (m_squash == 0);
      n_valid = int'(a_ok) + int'(l_ok) + int'(mul_wb_valid) + int'(div_wb_valid);
      if (n_valid > 1) m_coll = 1;
      e_we = 0; e_br = 0; ret = 0; e_rd = 0; e_data = 0; e_tgt = 0;
      if (div_wb_valid) begin
         e_we = 1; e_rd = div_wb_inf.rd; e_data = div_wb_inf.result; ret = 1;
      end else if (mul_wb_valid) begin
         e_we = 1; e_rd = mul_wb_inf.rd; e_data = mul_wb_inf.result; ret = 1;
      end else if (l_ok) begin
         e_rd = lst_wb_inf.rd;
         if (lst_wb_inf.replay) begin
            e_br = 1; e_tgt = lst_wb_inf.pc;
         end else begin
            e_we = lst_wb_inf.register_write; e_data = lst_wb_inf.result; ret = 1;
         end
      end else if (a_ok) begin
         e_we = alu_wb_inf.register_write; e_rd = alu_wb_inf.rd;
         e_data = alu_wb_inf.result; ret = 1;
         if (alu_wb_inf.redirect) begin
            e_br = 1; e_tgt = alu_wb_inf.target;
         end
      end
      if (e_rd == 0) e_we = 0;
      if (e_br) m_squash = SQ;
      else if (m_squash > 0) m_squash--;
      m_instret = (m_instret + int'(ret)) % (1 << IW);

      @(posedge clk);
      #1;
      check({tag, ".wr_en"}, 64'(wb_ix_inf.wr_en), 64'(e_we));
      if (e_we) begin
         check({tag, ".rd"},   64'(wb_ix_inf.rd), 64'(e_rd));
         check({tag, ".data"}, 64'(wb_ix_inf.wr_data), 64'(e_data));
      end
      check({tag, ".branch"}, 64'(wb_do_branch), 64'(e_br));
      if (e_br) check({tag, ".target"}, 64'(wb_branch_target), 64'(e_tgt));
      check({tag, ".instret"}, 64'(wb_instret), 64'(m_instret));
      check({tag, ".coll"}, 64'(wb_collision_err), 64'(m_coll));
   endtask

   task automatic drive_alu(input int unsigned rd, input bit rw, input int unsigned res,
                            input bit redir, input int unsigned tgt);
      alu_wb_valid = 1'b1;
      alu_wb_inf.rd = 5'(rd);
      alu_wb_inf.register_write = rw;
      alu_wb_inf.result = res;
      alu_wb_inf.redirect = redir;
      alu_wb_inf.target = tgt;
   endtask

   initial begin
      #2;
      check_reset_state("reset");
      #10 rst = 1'b1;
      @(posedge clk); #1;

      // MUL write
      idle_inputs();
      mul_wb_valid = 1'b1; mul_wb_inf.rd = 5'd5; mul_wb_inf.result = 32'hDEADBEEF;
      step("mul");

      // ALU redirect, then two squashed ALU results, then one that commits
      idle_inputs();
      drive_alu(9, 1, 32'h11, 1, 32'h200);
      step("redir");
      drive_alu(10, 1, 32'h22, 0, 0);
      step("squash1");
      step("squash2");
      step("post_squash");

      // LST replay, followed by squashed LST
      idle_inputs();
      lst_wb_valid = 1'b1;
      lst_wb_inf = '{rd: 5'd7, register_write: 1'b1, result: 32'h77, replay: 1'b1, pc: 32'h1040};
      step("replay");
      lst_wb_inf.replay = 1'b0;
      step("lst_squash");
      idle_inputs();
      step("idle1");
      step("idle2");

      // x0 write from ALU
      drive_alu(0, 1, 32'h55, 0, 0);
      step("x0");

      // Collision: DIV and ALU together
      div_wb_valid = 1'b1; div_wb_inf.rd = 5'd3; div_wb_inf.result = 32'hD1D1D1D1;
      drive_alu(4, 1, 32'h44, 0, 0);
      step("coll");
      idle_inputs();
      step("coll_sticky");

      // Wrap: 16 commits return the count to its starting value
      mul_wb_valid = 1'b1; mul_wb_inf.rd = 5'd1;
      for (int i = 0; i < 16; i++) begin
         mul_wb_inf.result = 32'(i);
         step("wrap");
      end
      idle_inputs();

      // Reset one cycle after a redirect
      drive_alu(2, 1, 32'h2, 1, 32'h300);
      step("pre_rst");
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_reset();
      check_reset_state("rst_mid");
      @(negedge clk);
      rst = 1'b1;
      drive_alu(6, 1, 32'h66, 0, 0);
      step("post_rst");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         alu_wb_valid = ($urandom_range(0, 3) == 0);
         alu_wb_inf = '{rd: 5'($urandom_range(0, 31)), register_write: 1'($urandom),
                        result: $urandom, redirect: ($urandom_range(0, 4) == 0), target: $urandom};
         lst_wb_valid = ($urandom_range(0, 4) == 0);
         lst_wb_inf = '{rd: 5'($urandom_range(0, 31)), register_write: 1'($urandom),
                        result: $urandom, replay: ($urandom_range(0, 4) == 0), pc: $urandom};
         mul_wb_valid = ($urandom_range(0, 7) == 0);
         mul_wb_inf = '{rd: 5'($urandom_range(0, 31)), result: $urandom};
         div_wb_valid = ($urandom_range(0, 11) == 0);
         div_wb_inf = '{rd: 5'($urandom_range(0, 31)), result: $urandom};
         if (i == 200) begin
            // Clear the sticky collision flag halfway so later traffic is checked fresh
            idle_inputs();
            @(negedge clk);
            rst = 1'b0;
            #1;
            model_reset();
            check_reset_state("rst_rand");
            @(negedge clk);
            rst = 1'b1;
         end
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
